// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream buffer: derived widths and the
// bit layout of one stored beat {tlast, tkeep, tdata}.
package axis_pkg;

    localparam int DATA_LSB = 0;

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int keep_lsb(input int data_w);
        return DATA_LSB + data_w;
    endfunction

    function automatic int last_bit(input int data_w);
        return keep_lsb(data_w) + keep_w(data_w);
    endfunction

    function automatic int beat_w(input int data_w);
        return data_w + keep_w(data_w) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// DEPTH x WIDTH flop array with one write port and one combinational
// read port; every entry clears on asynchronous reset.
module axis_fifo_mem #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_fifo_buffer.sv
// AXI4-Stream elastic buffer: wrap-bit pointers over a flop array, an
// explicit level counter, and registered tready / almost_full.
module axis_fifo_buffer
    import axis_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic [keep_w(DATA_W)-1:0]   s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic [keep_w(DATA_W)-1:0]   m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [cnt_w(DEPTH)-1:0]     level,
    output logic                        almost_full
);

    localparam int KEEP_W   = keep_w(DATA_W);
    localparam int CNT_W    = cnt_w(DEPTH);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int BEAT_W   = beat_w(DATA_W);
    localparam int KEEP_LSB = keep_lsb(DATA_W);
    localparam int LAST_BIT = last_bit(DATA_W);

    localparam logic [CNT_W-1:0] LVL_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LVL_AFULL = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] LVL_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic [CNT_W-1:0]   r_level;
    logic               r_tready;
    logic               r_afull;

    logic [PTR_W:0]     w_wr_ptr_nxt;
    logic [PTR_W:0]     w_rd_ptr_nxt;
    logic [CNT_W-1:0]   w_level_nxt;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_we;
    logic [BEAT_W-1:0]  w_wbeat;
    logic [BEAT_W-1:0]  w_rbeat;

    // Valid/ready: a beat moves on a rising edge where valid and ready are
    // both high. tready comes from a register, so the source side never sees
    // a combinational path from m_axis_tready.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = s_axis_tvalid & r_tready;
    assign w_pop   = ~w_empty & m_axis_tready;
    assign w_we    = w_push & ~clr;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + LVL_ONE;
                2'b01:   w_level_nxt = r_level - LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_tready <= 1'b0;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_tready <= (w_level_nxt < LVL_FULL);
            r_afull  <= (w_level_nxt >= LVL_AFULL);
        end
    end

    always_comb begin
        w_wbeat                        = '0;
        w_wbeat[DATA_LSB +: DATA_W]    = s_axis_tdata;
        w_wbeat[KEEP_LSB +: KEEP_W]    = s_axis_tkeep;
        w_wbeat[LAST_BIT]              = s_axis_tlast;
    end

    axis_fifo_mem #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (w_wbeat),
        .i_raddr (r_rd_ptr[PTR_W-1:0]),
        .o_rdata (w_rbeat)
    );

    assign m_axis_tdata  = w_rbeat[DATA_LSB +: DATA_W];
    assign m_axis_tkeep  = w_rbeat[KEEP_LSB +: KEEP_W];
    assign m_axis_tlast  = w_rbeat[LAST_BIT];
    assign m_axis_tvalid = ~w_empty;
    assign s_axis_tready = r_tready;
    assign level         = r_level;
    assign almost_full   = r_afull;

    // The pointer view and the counter view of occupancy must always agree.
    a_level_range: assert property (@(posedge clk) disable iff (!reset_n)
        r_level <= LVL_FULL);
    a_empty_level: assert property (@(posedge clk) disable iff (!reset_n)
        w_empty == (r_level == '0));
    a_full_level: assert property (@(posedge clk) disable iff (!reset_n)
        w_full == (r_level == LVL_FULL));

endmodule
